aes256_decrypt_core: RTL and testbench

- Iterative AES-256 decryption core (FIPS-197 inverse cipher); the receive-side counterpart of the team's AES-256 encryption datapath.
- Accepts a 256-bit key and a 128-bit ciphertext over a valid/ready handshake.
- Expands and stores all 15 round keys, then runs the inverse rounds one per cycle.
- Presents the 128-bit plaintext over a valid/ready output handshake.

---
 rtl/aes256_pkg.sv | 69 ++++++
 rtl/aes256_decrypt_core_if.sv | 9 +
 rtl/aes_inv_round.sv | 18 +
 rtl/aes256_decrypt_core.sv | 86 ++++++++
 tb/tb_aes256_decrypt_core.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/aes256_pkg.sv
// aes256_pkg: AES-256 constants, S-boxes, GF(2^8) helpers, round-key file and FSM encodings
package aes256_pkg;
  localparam int NR = 14;
  localparam int NK = 8;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_KEYEXP = 3'd1;
  localparam state_t ST_ADDKEY = 3'd2;
  localparam state_t ST_ROUND  = 3'd3;
  localparam state_t ST_FINAL  = 3'd4;
  localparam state_t ST_DONE   = 3'd5;
  typedef logic [NR:0][127:0] rk_file_t;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[{~x, 3'b111} -: 8];
  endfunction
  function automatic logic [7:0] rcon(input logic [2:0] i);
    return 8'h01 << (i - 3'd1);
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      p = b[i] ? p ^ t : p;
      t = xtime(t);
    end
    return p;
  endfunction
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 4'd14) ^ gf_mul(a1, 4'd11) ^ gf_mul(a2, 4'd13) ^ gf_mul(a3, 4'd9),
            gf_mul(a0, 4'd9)  ^ gf_mul(a1, 4'd14) ^ gf_mul(a2, 4'd11) ^ gf_mul(a3, 4'd13),
            gf_mul(a0, 4'd13) ^ gf_mul(a1, 4'd9)  ^ gf_mul(a2, 4'd14) ^ gf_mul(a3, 4'd11),
            gf_mul(a0, 4'd11) ^ gf_mul(a1, 4'd13) ^ gf_mul(a2, 4'd9)  ^ gf_mul(a3, 4'd14)};
  endfunction
endpackage

// File: rtl/aes256_decrypt_core_if.sv
// aes256_decrypt_core_if: key/ciphertext input and plaintext output valid/ready handshakes
interface aes256_decrypt_core_if;
  import aes256_pkg::*;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [32*NK-1:0] key;
  logic [127:0] ciphertext, plaintext;
  modport master(output in_valid, key, ciphertext, out_ready, input in_ready, out_valid, plaintext);
  modport slave(input in_valid, key, ciphertext, out_ready, output in_ready, out_valid, plaintext);
endinterface

// File: rtl/aes_inv_round.sv
// aes_inv_round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless skip_mix
module aes_inv_round
  import aes256_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         skip_mix,
  output logic [127:0] state_out
);
  logic [127:0] ark, mix;
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign ark[127-8*i -: 8] = inv_sbox(state_in[127-8*((((i/4)-(i%4))&3)*4+i%4) -: 8]) ^ round_key[127-8*i -: 8];
  end
  for (genvar i = 0; i < 4; i++) begin : g_col
    assign mix[127-32*i -: 32] = inv_mix_col(ark[127-32*i -: 32]);
  end
  assign state_out = skip_mix ? ark : mix;
endmodule

// File: rtl/aes256_decrypt_core.sv
// aes256_decrypt_core: iterative AES-256 inverse cipher; AES256_DEC_KEY_CACHE_EN skips re-expanding a repeated key
module aes256_decrypt_core
  import aes256_pkg::*;
(
  input logic clk,
  input logic rst,
  aes256_decrypt_core_if.slave bus
);
  state_t st;
  logic [3:0] cnt;
  rk_file_t rk;
  logic [127:0] blk, pt, pp, nxt, rnd_out;
  logic [31:0] last_w, tmp, n0, n1, n2;
  logic ov, hit;
  assign bus.in_ready  = !rst && st == ST_IDLE;
  assign bus.out_valid = ov;
  assign bus.plaintext = pt;
  assign last_w = rk[cnt - 4'd1][31:0];
  assign pp     = rk[cnt - 4'd2];
  assign tmp    = cnt[0] ? sub_word(last_w) : sub_word(rot_word(last_w)) ^ {rcon(cnt[3:1]), 24'h0};
  assign n0     = pp[127:96] ^ tmp;
  assign n1     = pp[95:64] ^ n0;
  assign n2     = pp[63:32] ^ n1;
  assign nxt    = {n0, n1, n2, pp[31:0] ^ n2};
`ifdef AES256_DEC_KEY_CACHE_EN
  logic key_cached;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_cached <= 1'b0;
    else if (st == ST_KEYEXP && cnt == 4'(NR)) key_cached <= 1'b1;
  end
  assign hit = key_cached && bus.key == {rk[0], rk[1]};
`else
  assign hit = 1'b0;
`endif
  aes_inv_round u_round (
    .state_in (blk),
    .round_key(rk[cnt]),
    .skip_mix (st == ST_FINAL),
    .state_out(rnd_out)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= ST_IDLE;
      cnt <= '0;
      rk  <= '0;
      blk <= '0;
      pt  <= '0;
      ov  <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: if (bus.in_valid) begin
          rk[0] <= bus.key[255:128];
          rk[1] <= bus.key[127:0];
          blk   <= bus.ciphertext;
          cnt   <= 4'd2;
          st    <= hit ? ST_ADDKEY : ST_KEYEXP;
        end
        ST_KEYEXP: begin
          rk[cnt] <= nxt;
          cnt     <= cnt + 4'd1;
          if (cnt == 4'(NR)) st <= ST_ADDKEY;
        end
        ST_ADDKEY: begin
          blk <= blk ^ rk[NR];
          cnt <= 4'(NR - 1);
          st  <= ST_ROUND;
        end
        ST_ROUND: begin
          blk <= rnd_out;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) st <= ST_FINAL;
        end
        ST_FINAL: begin
          pt <= rnd_out;
          ov <= 1'b1;
          st <= ST_DONE;
        end
        ST_DONE: if (bus.out_ready) begin
          ov <= 1'b0;
          st <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes256_decrypt_core.sv
// tb_aes256_decrypt_core: scoreboard bench using FIPS-197 C.3 and all-zero-key AES-256 vectors
module tb_aes256_decrypt_core;
`ifdef AES256_DEC_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam logic [255:0] K_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_C3 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K_Z   = 256'h0;
  localparam logic [127:0] CT_Z  = 128'hdc95c078a2408989ad48a21492842087;
  localparam logic [127:0] PT_Z  = 128'h0;
  typedef struct {
    logic [127:0] pt;
    int           lat;
    int           acc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  aes256_decrypt_core_if bus();
  aes256_decrypt_core dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t q[$];
  int n_cmp = 0, n_err = 0, cyc = 0, last_lat = 0;
  logic cached = 1'b0;
  logic [255:0] cached_key = '0;
  logic ov_q = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic send(input logic [255:0] k, input logic [127:0] c, input logic [127:0] p, output int w);
    exp_t e;
    w = 0;
    @(negedge clk);
    bus.key = k;
    bus.ciphertext = c;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, expected 1", w);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.pt  = p;
    e.lat = (CACHE && cached && k == cached_key) ? 15 : 28;
    e.acc = cyc;
    q.push_back(e);
    last_lat = e.lat;
    cached = 1'b1;
    cached_key = k;
    bus.in_valid = 1'b0;
    bus.key = ~k;
    bus.ciphertext = ~c;
  endtask
  task automatic drain();
    int w = 0;
    while ((q.size() != 0 || bus.out_valid) && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (w >= 100) begin
      n_err++;
      $display("FAIL drain_timeout: %0d results pending after %0d cycles, expected 0", q.size(), w);
    end
  endtask
  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    cached = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) ov_q = 1'b0;
    else begin
      if (bus.out_valid && !ov_q) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got %0h, expected no output", bus.plaintext);
        end else begin
          e = q.pop_front();
          chk("plaintext", bus.plaintext, e.pt);
          chk("latency", 128'(cyc - e.acc), 128'(e.lat));
        end
      end
      ov_q = bus.out_valid;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int w, l1;
    bus.in_valid = 1'b0;
    bus.key = '0;
    bus.ciphertext = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_plaintext", bus.plaintext, 128'h0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 128'(bus.in_ready), 128'(1));
    send(K_C3, CT_C3, PT_C3, w);
    drain();
    send(K_Z, CT_Z, PT_Z, w);
    drain();
    bus.out_ready = 1'b0;
    send(K_C3, CT_C3, PT_C3, w);
    w = 0;
    while (!bus.out_valid && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("bp_rise", 128'(bus.out_valid), 128'(1));
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", 128'(bus.out_valid), 128'(1));
      chk("bp_plaintext", bus.plaintext, PT_C3);
      chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_release_valid", 128'(bus.out_valid), 128'(0));
    chk("bp_release_in_ready", 128'(bus.in_ready), 128'(1));
    bus.out_ready = 1'b1;
    drain();
    send(K_C3, CT_C3, PT_C3, w);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("mid_rst_in_ready", 128'(bus.in_ready), 128'(0));
    q.delete();
    cached = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("post_rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("post_rst_plaintext", bus.plaintext, 128'h0);
    send(K_C3, CT_C3, PT_C3, w);
    drain();
    send(K_C3, CT_C3, PT_C3, w);
    l1 = last_lat;
    send(K_Z, CT_Z, PT_Z, w);
    chk("busy_wait", 128'(w), 128'(l1 + 1));
    drain();
    pulse_rst();
    send(K_C3, CT_C3, PT_C3, w);
    drain();
    send(K_C3, CT_C3, PT_C3, w);
    drain();
    send(K_Z, CT_Z, PT_Z, w);
    drain();
    chk("queue_empty", 128'(q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
